// File: rtl/mem_bank_if.sv
// Request/response bus of a single-port memory bank: valid/ready request channel,
// unthrottled read-response channel and the init-complete flag.
interface mem_bank_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int NBYTES = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [NBYTES-1:0]     req_be;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  init_done;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, init_done
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, init_done
  );
endinterface

// File: rtl/mem_bank_ctrl.sv
// Single-port memory bank with byte-lane writes, a fixed read latency of
// READ_LATENCY cycles and a zero-fill sweep after reset.
module mem_bank_ctrl #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  mem_bank_if.slave bus
);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $fatal(1, "mem_bank_ctrl: DATA_WIDTH must be a multiple of 8");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $fatal(1, "mem_bank_ctrl: READ_LATENCY must be within 1..4");
  end

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [ADDR_WIDTH-1:0] clr_addr_nxt;
  logic                  ready_q;
  logic                  ready_nxt;
  logic                  done_q;
  logic                  done_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  wr_acc;
  logic                  rd_acc;

  logic [READ_LATENCY-1:0] vld_p;
  logic [DATA_WIDTH-1:0]   data_p [READ_LATENCY];

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NBYTES-1:0]     be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < NBYTES; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  assign accept = bus.req_valid & ready_q;
  assign wr_acc = accept & bus.req_we;
  assign rd_acc = accept & ~bus.req_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR_ON_RESET ? S_INIT : S_READY;
      clr_addr <= '0;
      ready_q  <= 1'b0;
      done_q   <= !CLEAR_ON_RESET;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
      ready_q  <= ready_nxt;
      done_q   <= done_nxt;
    end
  end

  // ready/done are registered from the next state so both rise on the sweep's last edge
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    unique case (state)
      S_INIT: begin
        clr_addr_nxt = clr_addr + 1'b1;
        if (&clr_addr) state_nxt = S_READY;
      end
      S_READY: begin
        state_nxt = S_READY;
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
    ready_nxt = (state_nxt == S_READY);
    done_nxt  = (state_nxt == S_READY);
  end

  // Array write port: sweep owns it during INIT, requests otherwise
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem[bus.req_addr] <= merge_bytes(mem[bus.req_addr], bus.req_wdata, bus.req_be);
    end
  end

  // Stage p0 samples the array on the accept edge; later stages only shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      for (int i = 0; i < READ_LATENCY; i++) data_p[i] <= '0;
    end else begin
      vld_p[0] <= rd_acc;
      if (rd_acc) data_p[0] <= mem[bus.req_addr];
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) data_p[i] <= data_p[i-1];
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.init_done = done_q;
  assign bus.rsp_valid = vld_p[READ_LATENCY-1];
  assign bus.rsp_data  = data_p[READ_LATENCY-1];

endmodule
